// File: rtl/mem_stage_ctrl_if.sv
// Data-memory request/response bus between the MEM-stage sequencer and memory.
interface mem_stage_ctrl_if #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 16
);
  logic              dmem_read;
  logic              dmem_write;
  logic [ADDR_W-1:0] dmem_address;
  logic [DATA_W-1:0] dmem_wdata;
  logic [1:0]        dmem_byte_enable;
  logic              dmem_resp;
  logic [DATA_W-1:0] dmem_rdata;

  // Sequencer side: issues requests, receives completion and read data.
  modport master (
    output dmem_read, dmem_write, dmem_address, dmem_wdata, dmem_byte_enable,
    input  dmem_resp, dmem_rdata
  );

  // Memory side.
  modport slave (
    input  dmem_read, dmem_write, dmem_address, dmem_wdata, dmem_byte_enable,
    output dmem_resp, dmem_rdata
  );
endinterface

// File: rtl/mem_stage_ctrl.sv
// LC-3b MEM-stage sequencer: one access for plain loads/stores/trap fetches,
// two back-to-back accesses (pointer read, then data read/write) for LDI/STI.
// Stalls the pipeline until the operation completes and returns the loaded word.
module mem_stage_ctrl #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              valid,
  input  logic              mem_read,
  input  logic              mem_write,
  input  logic              is_ldi,
  input  logic              is_sti,
  input  logic              is_trap,
  input  logic [1:0]        mem_byte_enable,
  input  logic [ADDR_W-1:0] address,
  input  logic [DATA_W-1:0] wdata,
  mem_stage_ctrl_if.master  dmem,
  output logic [DATA_W-1:0] mdr,
  output logic              stall,
  output logic              done
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_ACC1 = 2'd1;
  localparam logic [1:0] S_ACC2 = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  logic [1:0]        state_q, state_d;
  // latched control word
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [1:0]        be_q, be_d;
  logic              rd_q, rd_d;     // first access is a read
  logic              wr_q, wr_d;     // first access is a plain write
  logic              ind_q, ind_d;   // LDI or STI: a second access follows
  logic              ldi_q, ldi_d;   // second access is a read (else write)
  logic [ADDR_W-1:0] ptr_q, ptr_d;   // word-aligned pointer from first access
  // registered request outputs
  logic              req_rd_q, req_rd_d;
  logic              req_wr_q, req_wr_d;
  logic [ADDR_W-1:0] req_addr_q, req_addr_d;
  logic [DATA_W-1:0] req_wdata_q, req_wdata_d;
  logic [1:0]        req_be_q, req_be_d;
  logic [DATA_W-1:0] mdr_q, mdr_d;

  logic              start;
  logic              req_busy;
  logic              resp_ok;
  logic              byte_store;
  logic [ADDR_W-1:0] rdata_as_addr;

  assign start    = valid & (mem_read | mem_write | is_ldi | is_sti) & (state_q == S_IDLE);
  assign req_busy = req_rd_q | req_wr_q;
  // A response only counts while a request is actually on the bus.
  assign resp_ok  = dmem.dmem_resp & req_busy;
  // Byte stores keep address bit 0 so memory can pick the lane.
  assign byte_store    = wr_q & ((be_q == 2'b01) | (be_q == 2'b10));
  assign rdata_as_addr = ADDR_W'(dmem.dmem_rdata);

  // Sequencer next-state and request generation.
  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    be_d        = be_q;
    rd_d        = rd_q;
    wr_d        = wr_q;
    ind_d       = ind_q;
    ldi_d       = ldi_q;
    ptr_d       = ptr_q;
    req_rd_d    = req_rd_q;
    req_wr_d    = req_wr_q;
    req_addr_d  = req_addr_q;
    req_wdata_d = req_wdata_q;
    req_be_d    = req_be_q;
    mdr_d       = mdr_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          addr_d  = address;
          wdata_d = wdata;
          be_d    = mem_byte_enable;
          rd_d    = mem_read | is_ldi | is_sti | is_trap;
          wr_d    = mem_write & ~(mem_read | is_ldi | is_sti | is_trap);
          ind_d   = is_ldi | is_sti;
          ldi_d   = is_ldi;
          state_d = S_ACC1;
        end
      end
      S_ACC1: begin
        if (resp_ok) begin
          req_rd_d = 1'b0;
          req_wr_d = 1'b0;
          if (ind_q) begin
            ptr_d   = {rdata_as_addr[ADDR_W-1:1], 1'b0};
            state_d = S_ACC2;
          end else begin
            if (rd_q) mdr_d = dmem.dmem_rdata;
            state_d = S_DONE;
          end
        end else if (!req_busy) begin
          req_rd_d   = rd_q;
          req_wr_d   = wr_q;
          req_addr_d = byte_store ? addr_q : {addr_q[ADDR_W-1:1], 1'b0};
          req_be_d   = wr_q ? be_q : 2'b11;
          if (wr_q) req_wdata_d = wdata_q;
        end
      end
      S_ACC2: begin
        if (resp_ok) begin
          req_rd_d = 1'b0;
          req_wr_d = 1'b0;
          if (ldi_q) mdr_d = dmem.dmem_rdata;
          state_d = S_DONE;
        end else if (!req_busy) begin
          req_rd_d   = ldi_q;
          req_wr_d   = ~ldi_q;
          req_addr_d = ptr_q;
          req_be_d   = 2'b11;
          if (!ldi_q) req_wdata_d = wdata_q;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and request registers; reset drops any in-flight request at once.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      addr_q      <= '0;
      wdata_q     <= '0;
      be_q        <= 2'b11;
      rd_q        <= 1'b0;
      wr_q        <= 1'b0;
      ind_q       <= 1'b0;
      ldi_q       <= 1'b0;
      ptr_q       <= '0;
      req_rd_q    <= 1'b0;
      req_wr_q    <= 1'b0;
      req_addr_q  <= '0;
      req_wdata_q <= '0;
      req_be_q    <= 2'b11;
      mdr_q       <= '0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      be_q        <= be_d;
      rd_q        <= rd_d;
      wr_q        <= wr_d;
      ind_q       <= ind_d;
      ldi_q       <= ldi_d;
      ptr_q       <= ptr_d;
      req_rd_q    <= req_rd_d;
      req_wr_q    <= req_wr_d;
      req_addr_q  <= req_addr_d;
      req_wdata_q <= req_wdata_d;
      req_be_q    <= req_be_d;
      mdr_q       <= mdr_d;
    end
  end

  assign dmem.dmem_read        = req_rd_q;
  assign dmem.dmem_write       = req_wr_q;
  assign dmem.dmem_address     = req_addr_q;
  assign dmem.dmem_wdata       = req_wdata_q;
  assign dmem.dmem_byte_enable = req_be_q;
  assign mdr   = mdr_q;
  // Combinational so the start cycle itself is frozen; DONE lets the pipe advance.
  assign stall = start | (state_q == S_ACC1) | (state_q == S_ACC2);
  assign done  = (state_q == S_DONE);

endmodule

// File: tb/tb_mem_stage_ctrl.sv
// Bench for mem_stage_ctrl: directed scenarios plus random operations, checked
// against an access-list / sparse-memory model of the MEM-stage behaviour.
module tb_mem_stage_ctrl;
  localparam int K_LD = 0, K_ST = 1, K_LDI = 2, K_STI = 3, K_TRAP = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        valid, mem_read, mem_write, is_ldi, is_sti, is_trap;
  logic [1:0]  mem_byte_enable;
  logic [15:0] address, wdata;
  logic [15:0] mdr;
  logic        stall, done;

  int checks = 0;
  int errors = 0;

  logic [15:0] mem [logic [15:0]];
  logic [15:0] exp_mdr;

  mem_stage_ctrl_if #(.ADDR_W(16), .DATA_W(16)) dif ();

  mem_stage_ctrl #(.ADDR_W(16), .DATA_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .valid(valid), .mem_read(mem_read),
    .mem_write(mem_write), .is_ldi(is_ldi), .is_sti(is_sti), .is_trap(is_trap),
    .mem_byte_enable(mem_byte_enable), .address(address), .wdata(wdata),
    .dmem(dif), .mdr(mdr), .stall(stall), .done(done)
  );

  always #5 clk = ~clk;

  task automatic chk1(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk16(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] mem_rd(input logic [15:0] a);
    logic [15:0] k;
    k = a & 16'hFFFE;
    if (mem.exists(k)) return mem[k];
    return (k * 16'd7) ^ 16'h5A5A;
  endfunction

  task automatic mem_wr(input logic [15:0] a, input logic [15:0] d, input logic [1:0] be);
    logic [15:0] k, cur;
    k   = a & 16'hFFFE;
    cur = mem_rd(k);
    if (be[0]) cur[7:0]  = d[7:0];
    if (be[1]) cur[15:8] = d[15:8];
    mem[k] = cur;
  endtask

  task automatic clear_inputs();
    valid = 0; mem_read = 0; mem_write = 0; is_ldi = 0; is_sti = 0; is_trap = 0;
    mem_byte_enable = 2'b11; address = '0; wdata = '0;
  endtask

  // One MEM-stage operation. The expected access list and completion time are
  // worked out up front; the loop plays memory and checks every cycle.
  // rst_at >= 0 asserts reset in that cycle instead of completing.
  task automatic do_op(input int kind, input logic [15:0] addr, input logic [15:0] wd,
                       input logic [1:0] be, input int w0, input int w1, input int rst_at);
    int          ek [2];
    logic [15:0] ea [2], ew [2];
    logic [1:0]  eb [2];
    int          ewt [2];
    int          nacc, done_cyc, ai, req_cnt;
    logic [15:0] aw, p, new_mdr;
    bit          finished;

    aw = addr & 16'hFFFE;
    ewt[0] = w0; ewt[1] = w1;
    ew[0] = wd; ew[1] = wd;
    new_mdr = exp_mdr;
    ek[0] = 0; ea[0] = aw; eb[0] = 2'b11; ek[1] = 0; ea[1] = '0; eb[1] = 2'b11;
    case (kind)
      K_ST: begin
        nacc = 1; ek[0] = 1; eb[0] = be;
        ea[0] = (be == 2'b01 || be == 2'b10) ? addr : aw;
      end
      K_LDI: begin
        nacc = 2; p = mem_rd(aw) & 16'hFFFE;
        ea[1] = p; new_mdr = mem_rd(p);
      end
      K_STI: begin
        nacc = 2; p = mem_rd(aw) & 16'hFFFE;
        ek[1] = 1; ea[1] = p;
      end
      default: begin
        nacc = 1; new_mdr = mem_rd(aw);
      end
    endcase
    done_cyc = 1;
    for (int i = 0; i < nacc; i++) done_cyc += ewt[i] + 2;

    @(negedge clk);
    clear_inputs();
    valid = 1; address = addr; wdata = wd; mem_byte_enable = be;
    case (kind)
      K_LD:    mem_read = 1;
      K_ST:    mem_write = 1;
      K_LDI:   begin is_ldi = 1; mem_read = 1; end
      K_STI:   begin is_sti = 1; mem_write = 1; end
      default: begin is_trap = 1; mem_read = 1; end
    endcase
    dif.dmem_resp = 0;
    ai = 0; req_cnt = 0; finished = 0;

    for (int c = 0; c <= done_cyc + 4 && !finished; c++) begin
      #1;
      chk1("stall", stall, c < done_cyc);
      chk1("done", done, c == done_cyc);
      chk1("rd_wr_excl", dif.dmem_read & dif.dmem_write, 1'b0);
      if (c == rst_at) begin
        rst_n = 0;
        clear_inputs();
        dif.dmem_resp = 0;
        #1;
        chk1("rst_read", dif.dmem_read, 1'b0);
        chk1("rst_write", dif.dmem_write, 1'b0);
        chk1("rst_stall", stall, 1'b0);
        chk1("rst_done", done, 1'b0);
        chk16("rst_mdr", mdr, 16'h0);
        exp_mdr = 16'h0;
        @(negedge clk); @(negedge clk);
        rst_n = 1;
        finished = 1;
      end else begin
        if (dif.dmem_read || dif.dmem_write) begin
          if (ai >= nacc) begin
            chk1("extra_req", dif.dmem_read | dif.dmem_write, 1'b0);
          end else begin
            if (req_cnt == 0) begin
              chk1("req_read", dif.dmem_read, ek[ai] == 0);
              chk1("req_write", dif.dmem_write, ek[ai] == 1);
              chk16("req_addr", dif.dmem_address, ea[ai]);
              chk16("req_be", 16'(dif.dmem_byte_enable), 16'(eb[ai]));
              if (ek[ai] == 1) chk16("req_wdata", dif.dmem_wdata, ew[ai]);
            end
            if (req_cnt == ewt[ai]) begin
              dif.dmem_resp = 1;
              if (ek[ai] == 0) dif.dmem_rdata = mem_rd(ea[ai]);
              else begin
                dif.dmem_rdata = 16'($urandom);
                mem_wr(ea[ai], ew[ai], eb[ai]);
              end
              ai++; req_cnt = 0;
            end else begin
              dif.dmem_resp = 0;
              req_cnt++;
            end
          end
        end else begin
          chk16("req_held", 16'(req_cnt), 16'd0);
          dif.dmem_resp = 0;
          dif.dmem_rdata = 16'($urandom);
        end
        if (c == done_cyc) begin
          exp_mdr = new_mdr;
          chk16("mdr", mdr, exp_mdr);
          chk16("acc_count", 16'(ai), 16'(nacc));
          clear_inputs();
          finished = 1;
        end
      end
      if (!finished) @(negedge clk);
    end
    if (!finished) chk1("op_timeout", done, 1'b1);
    clear_inputs();
    dif.dmem_resp = 0;
    @(negedge clk); #1;
    chk1("idle_stall", stall, 1'b0);
    chk1("idle_done", done, 1'b0);
    chk1("idle_read", dif.dmem_read, 1'b0);
  endtask

  initial begin
    int kind, w0, w1;
    logic [1:0] be;
    rst_n = 0;
    clear_inputs();
    dif.dmem_resp = 0;
    dif.dmem_rdata = '0;
    exp_mdr = '0;
    repeat (2) @(negedge clk);
    #1;
    chk1("reset_read", dif.dmem_read, 1'b0);
    chk1("reset_write", dif.dmem_write, 1'b0);
    chk16("reset_addr", dif.dmem_address, 16'h0);
    chk16("reset_wdata", dif.dmem_wdata, 16'h0);
    chk16("reset_be", 16'(dif.dmem_byte_enable), 16'h3);
    chk16("reset_mdr", mdr, 16'h0);
    chk1("reset_stall", stall, 1'b0);
    chk1("reset_done", done, 1'b0);
    @(negedge clk);
    rst_n = 1;

    // LDR with two wait states
    mem[16'h3004] = 16'hBEEF;
    do_op(K_LD, 16'h3005, 16'h0, 2'b11, 2, 0, -1);
    // STB upper lane, mdr untouched
    do_op(K_ST, 16'h4001, 16'h5500, 2'b10, 1, 0, -1);
    // LDI zero-wait
    mem[16'h2000] = 16'h6003;
    mem[16'h6002] = 16'h1234;
    do_op(K_LDI, 16'h2000, 16'h0, 2'b11, 0, 0, -1);
    // STI
    mem[16'h2000] = 16'h7000;
    do_op(K_STI, 16'h2000, 16'hCAFE, 2'b11, 0, 1, -1);
    do_op(K_LD, 16'h7000, 16'h0, 2'b11, 0, 0, -1);
    // trap fetch at odd vector address, word store at odd address
    do_op(K_TRAP, 16'h0025, 16'h0, 2'b11, 1, 0, -1);
    do_op(K_ST, 16'h5003, 16'h1357, 2'b11, 0, 0, -1);
    do_op(K_ST, 16'h5003, 16'h00AB, 2'b01, 0, 0, -1);

    // ADD-type pass-through with a spurious response in IDLE
    @(negedge clk);
    valid = 1;
    dif.dmem_resp = 1;
    dif.dmem_rdata = 16'hDEAD;
    #1;
    chk1("add_stall", stall, 1'b0);
    chk1("add_read", dif.dmem_read, 1'b0);
    chk1("add_done", done, 1'b0);
    @(negedge clk);
    dif.dmem_resp = 0;
    #1;
    chk16("spur_mdr", mdr, exp_mdr);
    chk1("spur_stall", stall, 1'b0);
    chk1("spur_done", done, 1'b0);
    chk1("spur_read", dif.dmem_read, 1'b0);
    clear_inputs();
    do_op(K_LD, 16'h3004, 16'h0, 2'b11, 0, 0, -1);

    // reset during the second LDI access, then a normal LDR
    do_op(K_LDI, 16'h2000, 16'h0, 2'b11, 0, 2, 5);
    do_op(K_LD, 16'h3005, 16'h0, 2'b11, 1, 0, -1);

    // random operations
    for (int n = 0; n < 30; n++) begin
      kind = int'($urandom_range(0, 4));
      be   = (kind == K_ST) ? 2'($urandom_range(1, 3)) : 2'b11;
      w0   = int'($urandom_range(0, 3));
      w1   = int'($urandom_range(0, 3));
      do_op(kind, 16'($urandom), 16'($urandom), be, w0, w1, -1);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
